// File: rtl/app_amem_sched.sv
// rtl/app_amem_sched.sv - round-robin scheduler sharing one analog memory core among APP channels
// Optional feature macro: APP_SCHED_STATS_EN adds timeout_cnt[7:0] and drop_cycles[15:0] outputs.
// Every output is a register. The output decode runs one cycle behind the FSM state, so a grant seen
// at edge k drives amem_tot high after edge k+1.

module app_amem_sched #(
  parameter int N_CH      = 4,
  parameter int DEPTH     = 16,
  parameter int FLUSH_CYC = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CH-1:0]                ch_req,
  input  logic [8*N_CH-1:0]              ch_meta,
  output logic [N_CH-1:0]                ch_ack,
  output logic [N_CH-1:0]                ch_rst_init,
  input  logic [7:0]                     tot_width,
  input  logic [15:0]                    timeout_threshold,
  input  logic                           timeout_enable,
  input  logic                           flush,
  output logic                           amem_tot,
  output logic [7:0]                     amem_metadata,
  output logic                           amem_resetb_full,
  output logic                           mem_full,
  output logic [$clog2(DEPTH+1)-1:0]     evt_count,
  output logic                           busy,
  output logic                           timeout_err
`ifdef APP_SCHED_STATS_EN
  ,
  output logic [7:0]                     timeout_cnt,
  output logic [15:0]                    drop_cycles
`endif
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int EW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TOT      = 3'd1,
    S_RECOVER  = 3'd2,
    S_WAIT_REL = 3'd3,
    S_FLUSH    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_win;
  logic [PW-1:0]     w_win;
  logic [PW:0]       w_idx;
  logic              w_found;
  logic [7:0]        r_tot_len;
  logic [15:0]       r_cnt;
  logic              r_flush_pend;
  logic [EW-1:0]     r_evt_count;
  logic [EW-1:0]     w_evt_inc;
  logic              r_mem_full;
  logic              r_timeout_err;
  logic [7:0]        r_meta;

  logic              w_flush_any;
  logic              w_grant;
  logic              w_tot_done;
  logic              w_released;
  logic              w_timeout;
  logic              w_to_fire;
  logic              w_flush_done;
  logic [N_CH-1:0]   w_win_onehot;

  logic              w_o_tot;
  logic [N_CH-1:0]   w_o_ack;
  logic [N_CH-1:0]   w_o_rst_init;
  logic              w_o_resetb;
  logic              w_o_busy;

  logic              r_amem_tot;
  logic [N_CH-1:0]   r_ch_ack;
  logic [N_CH-1:0]   r_ch_rst_init;
  logic              r_amem_resetb_full;
  logic              r_busy;

  // Round-robin search: first requesting channel at or above rr_ptr, wrapping to 0
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
      if (w_idx >= (PW+1)'(N_CH)) begin
        w_idx = w_idx - (PW+1)'(N_CH);
      end
      if (!w_found && ch_req[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PW-1:0];
      end
    end
  end

  assign w_flush_any  = flush | r_flush_pend;
  assign w_grant      = w_found & ~r_mem_full;
  assign w_tot_done   = (r_cnt == (16'(r_tot_len) - 16'd1));
  assign w_released   = ~ch_req[r_win];
  assign w_timeout    = timeout_enable && (r_cnt >= timeout_threshold);
  assign w_to_fire    = (r_state == S_WAIT_REL) && !w_released && w_timeout;
  assign w_flush_done = (r_cnt == 16'(FLUSH_CYC - 1));
  assign w_win_onehot = N_CH'(1) << r_win;
  assign w_evt_inc    = (r_evt_count == EW'(DEPTH)) ? r_evt_count : r_evt_count + EW'(1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic; a pending flush beats new requests in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_flush_any) begin
          w_next = S_FLUSH;
        end else if (w_grant) begin
          w_next = S_TOT;
        end
      end
      S_TOT: begin
        if (w_tot_done) begin
          w_next = S_RECOVER;
        end
      end
      S_RECOVER: begin
        w_next = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (w_released || w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (w_flush_done) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // FSM output decode, registered below
  always_comb begin
    w_o_tot      = (r_state == S_TOT);
    w_o_ack      = '0;
    w_o_rst_init = '0;
    if (r_state == S_RECOVER) begin
      w_o_ack      = w_win_onehot;
      w_o_rst_init = w_win_onehot;
    end else if (w_to_fire) begin
      w_o_rst_init = w_win_onehot;
    end
    w_o_resetb = (r_state != S_FLUSH);
    w_o_busy   = (r_state != S_IDLE);
  end

  // Per-state cycle counter, restarted on every state change and saturating
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) begin
      r_cnt <= '0;
    end else if (r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Grant bookkeeping, occupancy, flush request latch and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win         <= '0;
      r_meta        <= '0;
      r_tot_len     <= 8'd1;
      r_rr_ptr      <= '0;
      r_evt_count   <= '0;
      r_mem_full    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_flush_pend  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_next == S_TOT)) begin
        r_win     <= w_win;
        r_meta    <= ch_meta[{w_win, 3'b000} +: 8];
        r_tot_len <= (tot_width == 8'd0) ? 8'd1 : tot_width;
      end
      if (r_state == S_RECOVER) begin
        r_evt_count <= w_evt_inc;
        r_mem_full  <= (w_evt_inc == EW'(DEPTH));
        r_rr_ptr    <= (r_win == PW'(N_CH-1)) ? '0 : r_win + PW'(1);
      end
      if (w_to_fire) begin
        r_timeout_err <= 1'b1;
      end
      if ((r_state == S_FLUSH) && w_flush_done) begin
        r_evt_count   <= '0;
        r_mem_full    <= 1'b0;
        r_timeout_err <= 1'b0;
        r_flush_pend  <= 1'b0;
      end else if (flush && (r_state != S_FLUSH)) begin
        r_flush_pend  <= 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_amem_tot         <= 1'b0;
      r_ch_ack           <= '0;
      r_ch_rst_init      <= '0;
      r_amem_resetb_full <= 1'b1;
      r_busy             <= 1'b0;
    end else begin
      r_amem_tot         <= w_o_tot;
      r_ch_ack           <= w_o_ack;
      r_ch_rst_init      <= w_o_rst_init;
      r_amem_resetb_full <= w_o_resetb;
      r_busy             <= w_o_busy;
    end
  end

  assign amem_tot         = r_amem_tot;
  assign amem_metadata    = r_meta;
  assign amem_resetb_full = r_amem_resetb_full;
  assign ch_ack           = r_ch_ack;
  assign ch_rst_init      = r_ch_rst_init;
  assign mem_full         = r_mem_full;
  assign evt_count        = r_evt_count;
  assign busy             = r_busy;
  assign timeout_err      = r_timeout_err;

`ifdef APP_SCHED_STATS_EN
  logic [7:0]  r_timeout_cnt;
  logic [15:0] r_drop_cycles;

  // Saturating counts of timeouts and of request cycles stalled by a full memory
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_cnt <= '0;
      r_drop_cycles <= '0;
    end else begin
      if (w_to_fire && (r_timeout_cnt != 8'hFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
      if ((r_state == S_FLUSH) && w_flush_done) begin
        r_drop_cycles <= '0;
      end else if ((|ch_req) && r_mem_full && (r_drop_cycles != 16'hFFFF)) begin
        r_drop_cycles <= r_drop_cycles + 16'd1;
      end
    end
  end

  assign timeout_cnt = r_timeout_cnt;
  assign drop_cycles = r_drop_cycles;
`endif

endmodule

// File: tb/tb_app_amem_sched.sv
// tb/tb_app_amem_sched.sv - self-checking bench for app_amem_sched

module tb_app_amem_sched;
  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int FC    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  ch_req = '0;
  logic [8*N-1:0] ch_meta = '0;
  logic [N-1:0]  ch_ack;
  logic [N-1:0]  ch_rst_init;
  logic [7:0]    tot_width = 8'd1;
  logic [15:0]   timeout_threshold = 16'd0;
  logic          timeout_enable = 1'b0;
  logic          flush = 1'b0;
  logic          amem_tot;
  logic [7:0]    amem_metadata;
  logic          amem_resetb_full;
  logic          mem_full;
  logic [4:0]    evt_count;
  logic          busy;
  logic          timeout_err;
`ifdef APP_SCHED_STATS_EN
  logic [7:0]    timeout_cnt;
  logic [15:0]   drop_cycles;
`endif

  app_amem_sched #(.N_CH(N), .DEPTH(DEPTH), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_meta(ch_meta), .ch_ack(ch_ack),
    .ch_rst_init(ch_rst_init), .tot_width(tot_width), .timeout_threshold(timeout_threshold),
    .timeout_enable(timeout_enable), .flush(flush), .amem_tot(amem_tot),
    .amem_metadata(amem_metadata), .amem_resetb_full(amem_resetb_full), .mem_full(mem_full),
    .evt_count(evt_count), .busy(busy), .timeout_err(timeout_err)
`ifdef APP_SCHED_STATS_EN
    , .timeout_cnt(timeout_cnt), .drop_cycles(drop_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mon_tot = 0;
  int mon_rb  = 0;
  int mon_ack = 0;

  always @(negedge clk) begin
    if (amem_tot) mon_tot++;
    if (!amem_resetb_full) mon_rb++;
    if (ch_ack != '0) mon_ack++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_req = '0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Wait for one TOT pulse, check its length/metadata and the ack cycle that follows it
  task automatic serve_one(input int w, input logic [7:0] meta, input int len, input int evt);
    int n;
    int hi;
    bit meta_ok;
    n = 0;
    @(negedge clk);
    while (!amem_tot && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!amem_tot) begin
      chk("tot_start_timeout", 32'd0, 32'd1);
      return;
    end
    hi = 0;
    meta_ok = 1'b1;
    while (amem_tot && hi < 300) begin
      if (amem_metadata !== meta) meta_ok = 1'b0;
      hi++;
      @(negedge clk);
    end
    chk("tot_len", hi, len);
    chk("tot_meta", {31'd0, meta_ok}, 32'd1);
    chk("ack", {28'd0, ch_ack}, 32'd1 << w);
    chk("rst_init", {28'd0, ch_rst_init}, 32'd1 << w);
    chk("evt_count", {27'd0, evt_count}, evt);
    chk("mem_full", {31'd0, mem_full}, (evt == DEPTH) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_flush(output int lat, output int lo);
    lat = 0;
    while (amem_resetb_full && lat < 30) begin tick(); lat++; end
    lo = 0;
    while (!amem_resetb_full && lo < 50) begin tick(); lo++; end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] meta;
    logic [7:0]  tw;
    int          exp_w;
    logic [7:0]  exp_meta;
    int          exp_len;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n, lo, base_tot, base_ack, base_rb, w, mcnt, mptr, tw;
    logic [3:0] pend, add;
    logic [7:0] mmeta[N];
    bit do_fl;

    vt[0] = '{4'b0100, 32'h00A5_0000, 8'd3, 2, 8'hA5, 3};
    vt[1] = '{4'b0001, 32'h0000_003C, 8'd0, 0, 8'h3C, 1};
    vt[2] = '{4'b1000, 32'h7E00_0000, 8'd1, 3, 8'h7E, 1};
    vt[3] = '{4'b1010, 32'h1122_3344, 8'd5, 1, 8'h33, 5};
    vt[4] = '{4'b1111, 32'hDEAD_BEEF, 8'd2, 0, 8'hEF, 2};
    vt[5] = '{4'b0110, 32'h00FF_8100, 8'd4, 1, 8'h81, 4};

    // Reset values
    do_reset();
    chk("rst_amem_tot", {31'd0, amem_tot}, 0);
    chk("rst_metadata", {24'd0, amem_metadata}, 0);
    chk("rst_resetb", {31'd0, amem_resetb_full}, 1);
    chk("rst_ack", {28'd0, ch_ack | ch_rst_init}, 0);
    chk("rst_evt", {27'd0, evt_count}, 0);
    chk("rst_flags", {29'd0, mem_full, busy, timeout_err}, 0);

    // Table: single grant from reset (rr_ptr = 0) then release
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ch_meta = vt[i].meta; tot_width = vt[i].tw; ch_req = vt[i].req;
      serve_one(vt[i].exp_w, vt[i].exp_meta, vt[i].exp_len, 1);
      tick(); ch_req = '0;
      chk("ack_once", {28'd0, ch_ack | ch_rst_init}, 0);
      tick(); tick(); tick();
      chk("idle_busy", {31'd0, busy}, 0);
    end

    // Round robin with 1-cycle TOT
    do_reset();
    tot_width = 8'd0; ch_meta = 32'h4433_2211; ch_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w = k % N;
      serve_one(w, ch_meta[8*w +: 8], 1, k + 1);
      tick(); ch_req[w] = 1'b0;
      tick(); ch_req[w] = 1'b1;
    end
    ch_req = '0;

    // Occupancy limit and flush
    do_reset();
    tot_width = 8'd1;
    for (int i = 0; i < DEPTH; i++) begin
      ch_meta[8*(i%N) +: 8] = 8'(i);
      ch_req[i%N] = 1'b1;
      serve_one(i % N, 8'(i), 1, i + 1);
      tick(); ch_req[i%N] = 1'b0;
      tick();
    end
    ch_meta[15:8] = 8'h77; ch_req[1] = 1'b1;
    base_tot = mon_tot;
    repeat (30) tick();
    chk("full_no_tot", mon_tot - base_tot, 0);
    chk("full_flag", {31'd0, mem_full}, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    wait_flush(n, lo);
    chk("flush_low_cycles", lo, FC);
    chk("flush_evt_clear", {26'd0, mem_full, evt_count}, 0);
    serve_one(1, 8'h77, 1, 1);
    tick(); ch_req = '0; tick();

    // Release timeout, threshold 10, then sticky error cleared by flush
    do_reset();
    timeout_enable = 1'b1; timeout_threshold = 16'd10; tot_width = 8'd2;
    ch_meta = 32'h0000_5C00; ch_req = 4'b0010;
    serve_one(1, 8'h5C, 2, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ch_rst_init[1] && n < 60);
    chk("timeout_gap_10", n, 11);
    chk("timeout_err_set", {31'd0, timeout_err}, 1);
    serve_one(1, 8'h5C, 2, 2);
    tick(); ch_req = '0;
    repeat (5) tick();
    chk("timeout_err_sticky", {31'd0, timeout_err}, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    wait_flush(n, lo);
    chk("timeout_err_flushed", {31'd0, timeout_err}, 0);

    // Threshold 0 fires on the first release-wait cycle
    timeout_threshold = 16'd0;
    ch_meta = 32'h0042_0000; ch_req = 4'b0100;
    serve_one(2, 8'h42, 2, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ch_rst_init[2] && n < 60);
    chk("timeout_gap_0", n, 1);

    // Timeout disabled: waits indefinitely
    do_reset();
    timeout_enable = 1'b0; timeout_threshold = 16'd10; tot_width = 8'd1;
    ch_meta = 32'h0000_0099; ch_req = 4'b0001;
    serve_one(0, 8'h99, 1, 1);
    n = 0;
    repeat (40) begin @(negedge clk); if (ch_rst_init != '0) n++; end
    chk("no_timeout_pulses", n, 0);
    chk("no_timeout_busy", {30'd0, busy, timeout_err}, 2);
    tick(); ch_req = '0; tick(); tick(); tick();
    chk("no_timeout_release", {31'd0, busy}, 0);

    // Flush during TOT is deferred until WAIT_REL exits
    do_reset();
    tot_width = 8'd6; ch_meta = 32'h9900_0000;
    base_tot = mon_tot; base_ack = mon_ack; base_rb = mon_rb;
    ch_req = 4'b1000;
    n = 0;
    while (!amem_tot && n < 20) begin tick(); n++; end
    tick(); flush = 1'b1; tick(); flush = 1'b0;
    n = 0;
    while (!ch_ack[3] && n < 20) begin tick(); n++; end
    repeat (5) tick();
    chk("flush_deferred", mon_rb - base_rb, 0);
    ch_req = '0;
    wait_flush(n, lo);
    chk("flush_after_release_lat", n, 3);
    chk("flush_tot_len", mon_tot - base_tot, 6);
    chk("flush_one_ack", mon_ack - base_ack, 1);
    chk("flush_mid_low", lo, FC);
    chk("flush_mid_evt", {27'd0, evt_count}, 0);

    // Reset during TOT: no ack, pointer back to channel 0
    do_reset();
    tot_width = 8'd8; ch_meta = 32'h4433_2211; ch_req = 4'b0010;
    serve_one(1, 8'h22, 8, 1);
    tick(); ch_req = '0; tick(); tick();
    ch_req = 4'b0101;
    n = 0;
    while (!amem_tot && n < 20) begin tick(); n++; end
    tick(); tick();
    base_ack = mon_ack;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_tot", {29'd0, amem_tot, busy, amem_resetb_full}, 1);
    chk("rst_mid_ack", {28'd0, ch_ack | ch_rst_init}, 0);
    chk("rst_mid_evt_meta", {19'd0, evt_count, amem_metadata}, 0);
    serve_one(0, 8'h11, 8, 1);
    tick();
    chk("rst_mid_ack_count", mon_ack - base_ack, 1);
    ch_req = '0; tick(); tick();

    // Randomized grants against a transaction-level model
    do_reset();
    timeout_enable = 1'b0;
    pend = '0; mcnt = 0; mptr = 0;
    for (int c = 0; c < N; c++) mmeta[c] = 8'($urandom);
    tw = $urandom_range(0, 4);
    tot_width = 8'(tw);
    for (int g = 0; g < 40; g++) begin
      if (pend == '0) begin
        pend = 4'($urandom_range(1, 15));
        for (int c = 0; c < N; c++) begin
          if (pend[c]) mmeta[c] = 8'($urandom);
          ch_meta[8*c +: 8] = mmeta[c];
        end
        ch_req = pend;
      end
      w = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && pend[(mptr + i) % N]) w = (mptr + i) % N;
      end
      mcnt = (mcnt < DEPTH) ? mcnt + 1 : mcnt;
      serve_one(w, mmeta[w], (tw == 0) ? 1 : tw, mcnt);
      pend[w] = 1'b0;
      mptr = (w + 1) % N;
      add = 4'($urandom_range(0, 15)) & ~pend & ~(4'b0001 << w);
      for (int c = 0; c < N; c++) if (add[c]) mmeta[c] = 8'($urandom);
      pend = pend | add;
      tw = $urandom_range(0, 4);
      do_fl = (mcnt == DEPTH) || ($urandom_range(0, 9) == 0);
      if (do_fl) mcnt = 0;
      tick();
      ch_req = pend; tot_width = 8'(tw); flush = do_fl;
      for (int c = 0; c < N; c++) ch_meta[8*c +: 8] = mmeta[c];
      tick();
      flush = 1'b0;
    end
    ch_req = '0;
    repeat (10) tick();
    chk("rand_end_idle", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
